// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO behind a UART receiver with ack handshake; define UART_RX_FIFO_FWFT_EN for first-word fall-through reads
module uart_rx_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_ready_i,
  output logic                  rx_ack_o,
  input  logic                  rd_en_i,
  output logic [7:0]            rd_data_o,
  output logic                  rd_valid_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_full_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);
  typedef enum logic [1:0] {CAP_IDLE = 2'd0, CAP_ACK = 2'd1, CAP_RELEASE = 2'd2} cap_state_e;
  cap_state_e state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic wr_en, pop_en;
  assign count_o = count_q;
  assign empty_o = count_q == '0;
  assign full_o = count_q == DEPTH_C;
  assign almost_full_o = count_q >= AF_C;
  assign rx_ack_o = state_q == CAP_ACK;
  assign pop_en = rd_en_i && !empty_o;
  // capture handshake: take one byte, pulse ack, then wait for the receiver to drop ready
  always_comb begin
    state_d = CAP_IDLE;
    wr_en = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        wr_en = rx_ready_i && !full_o;
        state_d = wr_en ? CAP_ACK : CAP_IDLE;
      end
      CAP_ACK: state_d = CAP_RELEASE;
      CAP_RELEASE: state_d = rx_ready_i ? CAP_RELEASE : CAP_IDLE;
      default: state_d = CAP_IDLE;
    endcase
  end
  // pointer and occupancy next-state; pointers wrap naturally at the power-of-two depth
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + (ADDR_WIDTH+1)'(wr_en) - (ADDR_WIDTH+1)'(pop_en);
  end
  // control state registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= CAP_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // storage array, never cleared
  always_ff @(posedge clock_i) begin
    if (wr_en && !reset_i) mem_q[wr_ptr_q] <= rx_data_i;
  end
`ifdef UART_RX_FIFO_FWFT_EN
  assign rd_valid_o = !empty_o;
  assign rd_data_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];
`else
  logic [7:0] rd_data_q;
  logic rd_valid_q;
  // registered read port: data lands the cycle after a pop and holds otherwise
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_data_q <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop_en;
      if (pop_en) rd_data_q <= mem_q[rd_ptr_q];
    end
  end
  assign rd_data_o = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table vectors, directed corners and random traffic checked against a queue model
module tb_uart_rx_fifo;
  localparam int AW = 4, DEPTH = 16, AFL = 12;
  logic clock_i = 1'b0, reset_i = 1'b1, rx_ready_i = 1'b0, rd_en_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic rx_ack_o, rd_valid_o, empty_o, full_o, almost_full_o;
  logic [7:0] rd_data_o;
  logic [AW:0] count_o;
  int tests = 0, fails = 0;
  logic [7:0] mq[$], tx_q[$], out_q[$];
  bit taken, ack_due, rx_auto;
  int gap;
  logic [7:0] last_data;
  typedef struct {
    logic rdy; logic [7:0] d; logic rd;
    logic ack; logic [4:0] cnt; logic vld; logic [7:0] dat;
  } vec_t;
  vec_t vecs[10];

  always #5 clock_i = ~clock_i;

  uart_rx_fifo #(.ADDR_WIDTH(AW), .ALMOST_FULL_LEVEL(AFL)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .rx_data_i(rx_data_i), .rx_ready_i(rx_ready_i),
    .rx_ack_o(rx_ack_o), .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o), .almost_full_o(almost_full_o));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit cap, pop;
    logic [7:0] pd;
    pd = last_data;
    cap = rx_ready_i && !taken && (mq.size() < DEPTH);
    pop = rd_en_i && (mq.size() > 0);
    if (pop) begin
      pd = mq.pop_front();
      out_q.push_back(pd);
    end
    @(posedge clock_i); #1;
    if (cap) mq.push_back(rx_data_i);
    if (!rx_ready_i) taken = 1'b0;
    if (cap) taken = 1'b1;
    chk("ack", 32'(rx_ack_o), 32'(cap));
    chk("count", 32'(count_o), 32'(mq.size()));
    chk("empty", 32'(empty_o), 32'(mq.size() == 0));
    chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
    chk("almost_full", 32'(almost_full_o), 32'(mq.size() >= AFL));
`ifdef UART_RX_FIFO_FWFT_EN
    chk("valid", 32'(rd_valid_o), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("head", 32'(rd_data_o), 32'(mq[0]));
`else
    chk("valid", 32'(rd_valid_o), 32'(pop));
    chk("data", 32'(rd_data_o), 32'(pd));
`endif
    last_data = pd;
    if (rx_auto) begin
      if (ack_due) begin
        ack_due = 1'b0;
        rx_ready_i = 1'b0;
        gap = $urandom_range(1, 3);
      end else if (cap) ack_due = 1'b1;
      else if (!rx_ready_i) begin
        if (gap > 0) gap--;
        if (gap == 0 && tx_q.size() > 0) begin
          rx_ready_i = 1'b1;
          rx_data_i = tx_q.pop_front();
        end
      end
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    rx_ready_i = 1'b0;
    rd_en_i = 1'b0;
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    mq.delete(); tx_q.delete(); out_q.delete();
    taken = 1'b0; ack_due = 1'b0; gap = 0; last_data = 8'h00;
    chk("rst_ack", 32'(rx_ack_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_af", 32'(almost_full_o), 32'd0);
    chk("rst_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_data", 32'(rd_data_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 5'd1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 8'h3C, 1'b0, 1'b1, 5'd2, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 8'h3C, 1'b0, 1'b0, 5'd2, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b1, 8'hA5};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'h3C};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h3C};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 8'h3C};
    rx_auto = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rx_ready_i = vecs[i].rdy;
      rx_data_i = vecs[i].d;
      rd_en_i = vecs[i].rd;
      @(posedge clock_i); #1;
      chk($sformatf("vec%0d_ack", i), 32'(rx_ack_o), 32'(vecs[i].ack));
      chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty_o), 32'(vecs[i].cnt == 0));
`ifdef UART_RX_FIFO_FWFT_EN
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid_o), 32'(vecs[i].cnt != 0));
`else
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid_o), 32'(vecs[i].vld));
      chk($sformatf("vec%0d_data", i), 32'(rd_data_o), 32'(vecs[i].dat));
`endif
    end
    rx_ready_i = 1'b0; rd_en_i = 1'b0; taken = 1'b0; last_data = 8'h3C;
    // wrap-around continuing from the table state (pointers at 2 after the empty pop)
    rx_auto = 1'b1;
    for (int i = 0; i < 20; i++) tx_q.push_back(8'(i));
    n = 0;
    while ((tx_q.size() > 0 || rx_ready_i || mq.size() > 0) && n < 400) begin
      rd_en_i = 1'b1;
      step();
      n++;
    end
    rd_en_i = 1'b0;
    chk("wrap_bound", 32'(n < 400), 32'd1);
    chk("wrap_popped", 32'(out_q.size()), 32'd20);
    for (int i = 0; i < out_q.size(); i++) chk($sformatf("wrap_seq%0d", i), 32'(out_q[i]), 32'(i));
    // fill to full, stall a 17th byte, unblock with one pop
    do_reset();
    for (int i = 1; i <= 17; i++) tx_q.push_back(8'(i));
    n = 0;
    while (mq.size() < DEPTH && n < 300) begin step(); n++; end
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_af", 32'(almost_full_o), 32'd1);
    repeat (8) step();
    chk("stall_count", 32'(count_o), 32'd16);
    rd_en_i = 1'b1; step(); rd_en_i = 1'b0;
    n = 0;
    while (mq.size() < DEPTH && n < 20) begin step(); n++; end
    chk("refill_count", 32'(count_o), 32'd16);
    rd_en_i = 1'b1;
    repeat (18) step();
    rd_en_i = 1'b0;
    chk("drain_empty", 32'(empty_o), 32'd1);
    chk("drain_n", 32'(out_q.size()), 32'd17);
    for (int i = 0; i < out_q.size(); i++) chk($sformatf("full_seq%0d", i), 32'(out_q[i]), 32'(i + 1));
    // capture and pop on the same edge at count 5
    do_reset();
    for (int i = 0; i < 10; i++) tx_q.push_back(8'hC0 + 8'(i));
    n = 0;
    while (mq.size() < 5 && n < 100) begin step(); n++; end
    n = 0;
    while (!(rx_ready_i && !taken) && n < 20) begin step(); n++; end
    rd_en_i = 1'b1; step(); rd_en_i = 1'b0;
    chk("coincide_count", 32'(count_o), 32'd5);
    rd_en_i = 1'b1;
    repeat (40) step();
    rd_en_i = 1'b0;
    for (int i = 0; i < out_q.size(); i++) chk($sformatf("coin_seq%0d", i), 32'(out_q[i]), 32'(8'hC0 + i));
    // reset while the ack pulse is high
    do_reset();
    for (int i = 0; i < 10; i++) tx_q.push_back(8'h70 + 8'(i));
    n = 0;
    while (mq.size() < 7 && n < 100) begin step(); n++; end
    chk("pre_reset_ack", 32'(rx_ack_o), 32'd1);
    chk("pre_reset_count", 32'(count_o), 32'd7);
    do_reset();
    rx_ready_i = 1'b1; rx_data_i = 8'h99;
    repeat (6) step();
    rd_en_i = 1'b1; repeat (3) step(); rd_en_i = 1'b0;
    chk("post_reset_byte", 32'(out_q.size() > 0 ? out_q[0] : 8'h00), 32'h99);
    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) tx_q.push_back(8'($urandom));
    for (int c = 0; c < 3000; c++) begin
      rd_en_i = $urandom_range(0, 99) < ((c < 1500) ? 12 : 85);
      step();
    end
    rd_en_i = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
